// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream demultiplexer.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } demux_state_t;

  // Widest select vector is_onehot accepts; callers zero-extend into it.
  localparam int MAX_CH = 64;

  function automatic logic is_onehot(input logic [MAX_CH-1:0] v);
    return (v != '0) && ((v & (v - MAX_CH'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-entry register slice carrying data, last and a select sideband.
// It can load and drain in the same cycle, so it runs at full throughput.
module axis_pipe_reg
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  drain,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [SEL_WIDTH-1:0]  in_sel,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [SEL_WIDTH-1:0]  out_sel
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
      sel_d   = in_sel;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;

endmodule

// File: rtl/axis_demux.sv
// Packet-locked 1-to-CHANNEL AXI-Stream demux. The destination is latched on
// the first beat of a packet; packets with a non-one-hot switch are dropped.
module axis_demux
  import axis_pkg::*;
#(
  parameter int CHANNEL    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                s_axis_tlast,
  output logic [CHANNEL-1:0][DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [CHANNEL-1:0]                  m_axis_tvalid,
  input  logic [CHANNEL-1:0]                  m_axis_tready,
  output logic [CHANNEL-1:0]                  m_axis_tlast,
  input  logic [CHANNEL-1:0]                  switch,
  output logic                                busy,
  output logic [CNT_WIDTH-1:0]                drop_cnt
);

  demux_state_t          state_q, state_d;
  logic [CHANNEL-1:0]    pkt_sel_q, pkt_sel_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic                  out_valid, out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CHANNEL-1:0]    out_sel;
  logic                  drain, rdy, accept, sw_ok, load;
  logic [CHANNEL-1:0]    load_sel;
  logic [MAX_CH-1:0]     sw_ext;

  assign drain  = out_valid & |(out_sel & m_axis_tready);
  assign rdy    = !out_valid | drain;
  assign accept = s_axis_tvalid & s_axis_tready;

  always_comb begin
    sw_ext = '0;
    sw_ext[CHANNEL-1:0] = switch;
    sw_ok = is_onehot(sw_ext);
  end

  // A dropped packet is swallowed at line rate regardless of the output register.
  always_comb begin
    if (rst)                  s_axis_tready = 1'b0;
    else if (state_q == DROP) s_axis_tready = 1'b1;
    else                      s_axis_tready = rdy;
  end

  always_comb begin
    state_d    = state_q;
    pkt_sel_d  = pkt_sel_q;
    drop_cnt_d = drop_cnt_q;
    load       = 1'b0;
    load_sel   = pkt_sel_q;
    case (state_q)
      IDLE: if (accept) begin
        if (sw_ok) begin
          load      = 1'b1;
          load_sel  = switch;
          pkt_sel_d = switch;
          if (!s_axis_tlast) state_d = FWD;
        end else begin
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
          if (!s_axis_tlast) state_d = DROP;
        end
      end
      FWD: if (accept) begin
        load = 1'b1;
        if (s_axis_tlast) state_d = IDLE;
      end
      DROP: if (accept && s_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pkt_sel_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_sel_q  <= pkt_sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  axis_pipe_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEL_WIDTH  (CHANNEL)
  ) u_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .drain     (drain),
    .in_data   (s_axis_tdata),
    .in_last   (s_axis_tlast),
    .in_sel    (load_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  for (genvar i = 0; i < CHANNEL; i++) begin : g_lane
    assign m_axis_tdata[i]  = out_data;
    assign m_axis_tvalid[i] = out_valid & out_sel[i];
    assign m_axis_tlast[i]  = out_last & out_sel[i];
  end

  assign busy     = (state_q != IDLE) | out_valid;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_axis_demux.sv
// Directed bench for axis_demux with CHANNEL=2; expectations are hand-computed.
module tb_axis_demux;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [1:0][31:0]  m_axis_tdata;
  logic [1:0]        m_axis_tvalid;
  logic [1:0]        m_axis_tready;
  logic [1:0]        m_axis_tlast;
  logic [1:0]        switch;
  logic              busy;
  logic [15:0]       drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_demux #(.CHANNEL(2), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .switch        (switch),
    .busy          (busy),
    .drop_cnt      (drop_cnt)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic v, input logic l, input logic [1:0] sw);
    s_axis_tdata = d; s_axis_tvalid = v; s_axis_tlast = l; switch = sw;
  endtask

  task automatic test_reset;
    rst = 1'b1; m_axis_tready = 2'b11;
    drive(32'h0, 1'b0, 1'b0, 2'b00);
    tick; tick;
    checks++; if (m_axis_tvalid !== 2'b00) begin errors++; $display("FAIL reset_tvalid: got %b want 00", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 2'b00) begin errors++; $display("FAIL reset_tlast: got %b want 00", m_axis_tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready_in_rst: got %b want 0", s_axis_tready); end
    rst = 1'b0; #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready_after: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_steering;
    m_axis_tready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      drive(32'hA0 + k, 1'b1, k == 3, 2'b01);
      #1;
      checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL steer_tready beat %0d: got %b want 1", k, s_axis_tready); end
      tick;
      checks++; if (m_axis_tvalid !== 2'b01) begin errors++; $display("FAIL steer_tvalid beat %0d: got %b want 01", k, m_axis_tvalid); end
      checks++; if (m_axis_tdata[0] !== 32'hA0 + k) begin errors++; $display("FAIL steer_data beat %0d: got %h want %h", k, m_axis_tdata[0], 32'hA0 + k); end
      checks++; if (m_axis_tlast !== ((k == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL steer_tlast beat %0d: got %b", k, m_axis_tlast); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL steer_busy beat %0d: got %b want 1", k, busy); end
    end
    drive(32'h0, 1'b0, 1'b0, 2'b01);
    tick;
    checks++; if (m_axis_tvalid !== 2'b00) begin errors++; $display("FAIL steer_idle_tvalid: got %b want 00", m_axis_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL steer_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_switch_change;
    logic [1:0] sw;
    m_axis_tready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      sw = (k >= 2) ? 2'b10 : 2'b01;
      drive(32'hD0 + k, 1'b1, k == 3, sw);
      tick;
      checks++; if (m_axis_tvalid !== 2'b01) begin errors++; $display("FAIL swchg_lane beat %0d: got %b want 01", k, m_axis_tvalid); end
      checks++; if (m_axis_tdata[0] !== 32'hD0 + k) begin errors++; $display("FAIL swchg_data beat %0d: got %h want %h", k, m_axis_tdata[0], 32'hD0 + k); end
    end
    drive(32'hD4, 1'b1, 1'b1, 2'b10);
    tick;
    checks++; if (m_axis_tvalid !== 2'b10) begin errors++; $display("FAIL swchg_next_pkt_lane: got %b want 10", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 2'b10) begin errors++; $display("FAIL swchg_next_pkt_last: got %b want 10", m_axis_tlast); end
    checks++; if (m_axis_tdata[1] !== 32'hD4) begin errors++; $display("FAIL swchg_next_pkt_data: got %h want d4", m_axis_tdata[1]); end
    drive(32'h0, 1'b0, 1'b0, 2'b00);
    tick;
  endtask

  task automatic test_back_to_back;
    m_axis_tready = 2'b11;
    drive(32'hB0, 1'b1, 1'b1, 2'b01);
    tick;
    checks++; if (m_axis_tvalid !== 2'b01) begin errors++; $display("FAIL b2b_first_lane: got %b want 01", m_axis_tvalid); end
    checks++; if (m_axis_tdata[0] !== 32'hB0) begin errors++; $display("FAIL b2b_first_data: got %h want b0", m_axis_tdata[0]); end
    drive(32'hB1, 1'b1, 1'b1, 2'b10);
    #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL b2b_tready: got %b want 1", s_axis_tready); end
    tick;
    checks++; if (m_axis_tvalid !== 2'b10) begin errors++; $display("FAIL b2b_second_lane: got %b want 10", m_axis_tvalid); end
    checks++; if (m_axis_tdata[1] !== 32'hB1) begin errors++; $display("FAIL b2b_second_data: got %h want b1", m_axis_tdata[1]); end
    drive(32'h0, 1'b0, 1'b0, 2'b00);
    tick;
    checks++; if (m_axis_tvalid !== 2'b00) begin errors++; $display("FAIL b2b_drained: got %b want 00", m_axis_tvalid); end
  endtask

  task automatic test_backpressure;
    m_axis_tready = 2'b11;
    drive(32'hA0, 1'b1, 1'b0, 2'b01);
    tick;
    // Only the unselected lane is ready while stalled: it must not drain lane 0.
    m_axis_tready = 2'b10;
    drive(32'hA1, 1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_tready cycle %0d: got %b want 0", i, s_axis_tready); end
      tick;
      checks++; if (m_axis_tvalid !== 2'b01) begin errors++; $display("FAIL bp_hold_valid cycle %0d: got %b want 01", i, m_axis_tvalid); end
      checks++; if (m_axis_tdata[0] !== 32'hA0) begin errors++; $display("FAIL bp_hold_data cycle %0d: got %h want a0", i, m_axis_tdata[0]); end
    end
    m_axis_tready = 2'b01;
    #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL bp_release_tready: got %b want 1", s_axis_tready); end
    tick;
    for (int k = 1; k < 4; k++) begin
      checks++; if (m_axis_tdata[0] !== 32'hA0 + k || m_axis_tvalid !== 2'b01) begin errors++; $display("FAIL bp_order beat %0d: got %h/%b want %h/01", k, m_axis_tdata[0], m_axis_tvalid, 32'hA0 + k); end
      if (k < 3) begin
        drive(32'hA1 + k, 1'b1, k == 2, 2'b01);
        tick;
      end
    end
    checks++; if (m_axis_tlast !== 2'b01) begin errors++; $display("FAIL bp_last: got %b want 01", m_axis_tlast); end
    drive(32'h0, 1'b0, 1'b0, 2'b00);
    tick;
    checks++; if (m_axis_tvalid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got valid %b busy %b want 00/0", m_axis_tvalid, busy); end
  endtask

  task automatic test_invalid_switch;
    m_axis_tready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      drive(32'hE0 + k, 1'b1, k == 2, 2'b00);
      #1;
      checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL drop_tready beat %0d: got %b want 1", k, s_axis_tready); end
      tick;
      checks++; if (m_axis_tvalid !== 2'b00) begin errors++; $display("FAIL drop_valid beat %0d: got %b want 00", k, m_axis_tvalid); end
      checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt_pkt1 beat %0d: got %0d want 1", k, drop_cnt); end
    end
    drive(32'hE3, 1'b1, 1'b1, 2'b11);
    #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL drop_multihot_tready: got %b want 1", s_axis_tready); end
    tick;
    checks++; if (m_axis_tvalid !== 2'b00) begin errors++; $display("FAIL drop_multihot_valid: got %b want 00", m_axis_tvalid); end
    drive(32'h0, 1'b0, 1'b0, 2'b00);
    tick;
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt_final: got %0d want 2", drop_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_packet;
    m_axis_tready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      drive(32'hF0 + k, 1'b1, 1'b0, 2'b01);
      tick;
    end
    drive(32'h0, 1'b0, 1'b0, 2'b01);
    rst = 1'b1;
    tick;
    checks++; if (m_axis_tvalid !== 2'b00) begin errors++; $display("FAIL rstmid_valid: got %b want 00", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 2'b00) begin errors++; $display("FAIL rstmid_last: got %b want 00", m_axis_tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_drop_cnt: got %0d want 0", drop_cnt); end
    rst = 1'b0;
    drive(32'hC0, 1'b1, 1'b1, 2'b10);
    tick;
    checks++; if (m_axis_tvalid !== 2'b10) begin errors++; $display("FAIL rstmid_new_lane: got %b want 10", m_axis_tvalid); end
    checks++; if (m_axis_tdata[1] !== 32'hC0) begin errors++; $display("FAIL rstmid_new_data: got %h want c0", m_axis_tdata[1]); end
    checks++; if (m_axis_tlast !== 2'b10) begin errors++; $display("FAIL rstmid_new_last: got %b want 10", m_axis_tlast); end
    drive(32'h0, 1'b0, 1'b0, 2'b00);
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_final_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_steering;
    test_switch_change;
    test_back_to_back;
    test_backpressure;
    test_invalid_switch;
    test_reset_mid_packet;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
